// File: rtl/seq_monitor_pkg.sv
// Shared definitions for the T-flip-flop counter sequence monitor:
// FSM encoding, successor table and code-class sets.
package seq_monitor_pkg;

   typedef logic [2:0] code_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2,
      ST_FAULT  = 2'd3
   } state_t;

   // Expected next code for each sampled code of the upstream counter
   localparam code_t SUCC_0 = 3'd3;
   localparam code_t SUCC_1 = 3'd5;
   localparam code_t SUCC_2 = 3'd3;
   localparam code_t SUCC_3 = 3'd6;
   localparam code_t SUCC_4 = 3'd6;
   localparam code_t SUCC_5 = 3'd1;
   localparam code_t SUCC_6 = 3'd2;
   localparam code_t SUCC_7 = 3'd5;

   // One-hot membership masks indexed by code value
   localparam logic [7:0] LOOP_SET   = 8'b0100_1100;  // {2,3,6}
   localparam logic [7:0] LOCKUP_SET = 8'b1010_0010;  // {1,5,7}
   localparam logic [7:0] ALT_SET    = 8'b0010_0010;  // {1,5}

   function automatic code_t succ(input code_t c);
      code_t s;
      case (c)
         3'd0:    s = SUCC_0;
         3'd1:    s = SUCC_1;
         3'd2:    s = SUCC_2;
         3'd3:    s = SUCC_3;
         3'd4:    s = SUCC_4;
         3'd5:    s = SUCC_5;
         3'd6:    s = SUCC_6;
         default: s = SUCC_7;
      endcase
      return s;
   endfunction

   function automatic logic in_loop(input code_t c);
      return LOOP_SET[c];
   endfunction

   function automatic logic is_lockup_code(input code_t c);
      return LOCKUP_SET[c];
   endfunction

   function automatic logic is_legal(input code_t p, input code_t c);
      return !LOCKUP_SET[p] && (c == succ(p));
   endfunction

   // True for the pairs 1->5 and 5->1
   function automatic logic is_alt_pair(input code_t p, input code_t c);
      return ALT_SET[p] && ALT_SET[c] && (p != c);
   endfunction

endpackage

// File: rtl/seq_monitor_if.sv
// Sample/status bundle between the counter under observation and the monitor.
interface seq_monitor_if #(
   parameter int ERR_W = 8
);
   import seq_monitor_pkg::*;

   logic             i_en;
   logic             i_q_a;
   logic             i_q_b;
   logic             i_q_c;
   logic             i_clr_err;
   code_t            o_code;
   logic             o_locked;
   logic             o_wrap;
   logic             o_err;
   logic [ERR_W-1:0] o_err_cnt;
   logic             o_lockup;

   modport master (
      output i_en, i_q_a, i_q_b, i_q_c, i_clr_err,
      input  o_code, o_locked, o_wrap, o_err, o_err_cnt, o_lockup
   );

   modport slave (
      input  i_en, i_q_a, i_q_b, i_q_c, i_clr_err,
      output o_code, o_locked, o_wrap, o_err, o_err_cnt, o_lockup
   );

endinterface

// File: rtl/seq_monitor_sat_counter.sv
// Saturating event counter; an increment in the same cycle as a clear restarts at 1.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] MAX_CNT = '1;

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_inc) begin
         if (i_clr)
            r_count <= WIDTH'(1);
         else if (r_count != MAX_CNT)
            r_count <= r_count + 1'b1;
      end else if (i_clr) begin
         r_count <= '0;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/seq_monitor.sv
// Watches the 3-bit code of an upstream T-flip-flop counter, acquires lock on its
// {3,6,2} loop, flags loop faults and detects the 1<->5 lock-up oscillation.
module seq_monitor #(
   parameter int LOCK_N = 3,
   parameter int ERR_W  = 8
) (
   input logic          clk,
   input logic          rst_n,
   seq_monitor_if.slave bus
);
   import seq_monitor_pkg::*;

   localparam int RUN_W = $clog2(LOCK_N + 1);

   state_t           r_state;
   state_t           w_state_next;
   code_t            r_prev;
   code_t            w_prev_next;
   logic [RUN_W-1:0] r_run;
   logic [RUN_W-1:0] w_run_next;
   logic [RUN_W-1:0] w_run_inc;
   code_t            r_code;
   code_t            w_code_next;
   logic             r_wrap;
   logic             w_wrap_next;
   logic             r_lockup;
   logic             w_lockup_next;
   logic             r_err;
   logic             w_err_next;
   logic             w_fault;
   logic             w_clr;
   logic             w_legal;
   code_t            w_cur;
   logic [ERR_W-1:0] w_err_cnt;

   assign w_cur     = {bus.i_q_a, bus.i_q_b, bus.i_q_c};
   assign w_legal   = is_legal(r_prev, w_cur);
   assign w_run_inc = r_run + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_prev   <= '0;
         r_run    <= '0;
         r_code   <= '0;
         r_wrap   <= 1'b0;
         r_lockup <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_prev   <= w_prev_next;
         r_run    <= w_run_next;
         r_code   <= w_code_next;
         r_wrap   <= w_wrap_next;
         r_lockup <= w_lockup_next;
         r_err    <= w_err_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_prev_next   = r_prev;
      w_run_next    = r_run;
      w_code_next   = r_code;
      w_wrap_next   = 1'b0;
      w_lockup_next = r_lockup;
      w_err_next    = r_err;
      w_fault       = 1'b0;
      w_clr         = 1'b0;

      if (bus.i_en) begin
         w_code_next = w_cur;
         w_prev_next = w_cur;
         w_clr       = bus.i_clr_err;

         // Lock-up flag holds while the samples stay inside {1,5} without a fresh pair
         if (is_alt_pair(r_prev, w_cur))
            w_lockup_next = 1'b1;
         else if (!ALT_SET[w_cur])
            w_lockup_next = 1'b0;

         case (r_state)
            ST_IDLE: begin
               w_state_next = ST_HUNT;
               w_run_next   = '0;
            end
            ST_HUNT: begin
               if (w_legal && in_loop(w_cur)) begin
                  if (w_run_inc == RUN_W'(LOCK_N)) begin
                     w_state_next = ST_LOCKED;
                     w_run_next   = '0;
                  end else begin
                     w_run_next = w_run_inc;
                  end
               end else begin
                  w_run_next = '0;
               end
            end
            ST_LOCKED: begin
               if (w_legal && !is_lockup_code(w_cur)) begin
                  w_wrap_next = (r_prev == 3'd2) && (w_cur == 3'd3);
               end else begin
                  w_state_next = ST_FAULT;
                  w_fault      = 1'b1;
               end
            end
            ST_FAULT: begin
               if (in_loop(w_cur)) begin
                  w_state_next = ST_HUNT;
                  w_run_next   = '0;
               end
            end
            default: w_state_next = ST_IDLE;
         endcase

         // A new fault overrides a simultaneous clear request
         if (w_fault)
            w_err_next = 1'b1;
         else if (w_clr)
            w_err_next = 1'b0;
      end
   end

   sat_counter #(
      .WIDTH (ERR_W)
   ) u_err_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_fault),
      .i_clr   (w_clr),
      .o_count (w_err_cnt)
   );

   assign bus.o_code    = r_code;
   assign bus.o_locked  = (r_state == ST_LOCKED);
   assign bus.o_wrap    = r_wrap;
   assign bus.o_err     = r_err;
   assign bus.o_err_cnt = w_err_cnt;
   assign bus.o_lockup  = r_lockup;

endmodule

// File: tb/tb_seq_monitor.sv
// Randomised and directed bench for seq_monitor with a queue-based scoreboard
// fed by a behavioural model of the counter-monitor rules.
module tb_seq_monitor;

   localparam int LOCK_N  = 3;
   localparam int ERR_W   = 8;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   typedef struct {
      int code;
      int locked;
      int wrap;
      int err;
      int cnt;
      int lockup;
   } exp_t;

   logic clk;
   logic rst_n;

   seq_monitor_if #(.ERR_W(ERR_W)) bus ();

   seq_monitor #(
      .LOCK_N (LOCK_N),
      .ERR_W  (ERR_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_tx     = 0;
   bit   mon_en   = 0;
   bit   release_now = 0;
   exp_t exp_q[$];

   // Reference model state
   int succ_tbl[8] = '{3, 5, 3, 6, 6, 1, 2, 5};
   bit m_started;
   int m_prev, m_run;
   bit m_locked, m_faulted;
   int m_code, m_wrap, m_err, m_cnt, m_lockup;

   task automatic chk(input string name, input int got, input int want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_started = 0; m_prev = 0; m_run = 0; m_locked = 0; m_faulted = 0;
      m_code = 0; m_wrap = 0; m_err = 0; m_cnt = 0; m_lockup = 0;
   endtask

   task automatic model_sample(input int c, input bit clr);
      bit legal, fault;
      fault  = 0;
      m_wrap = 0;
      if ((m_prev == 1 && c == 5) || (m_prev == 5 && c == 1)) m_lockup = 1;
      else if (!(c inside {1, 5})) m_lockup = 0;
      if (!m_started) begin
         m_started = 1;
         m_run     = 0;
      end else begin
         legal = !(m_prev inside {1, 5, 7}) && (c == succ_tbl[m_prev]);
         if (m_locked) begin
            if (legal && !(c inside {1, 5, 7})) begin
               if (m_prev == 2 && c == 3) m_wrap = 1;
            end else begin
               m_locked = 0; m_faulted = 1; fault = 1;
            end
         end else if (m_faulted) begin
            if (c inside {2, 3, 6}) begin m_faulted = 0; m_run = 0; end
         end else begin
            if (legal && (c inside {2, 3, 6})) begin
               m_run++;
               if (m_run == LOCK_N) begin m_locked = 1; m_run = 0; end
            end else begin
               m_run = 0;
            end
         end
      end
      if (fault) begin
         m_err = 1;
         m_cnt = clr ? 1 : ((m_cnt < ERR_MAX) ? m_cnt + 1 : ERR_MAX);
      end else if (clr) begin
         m_err = 0; m_cnt = 0;
      end
      m_prev = c;
      m_code = c;
   endtask

   task automatic push_exp(input bit en, input int c, input bit clr);
      exp_t e;
      e.code = m_code; e.locked = m_locked; e.wrap = m_wrap;
      e.err = m_err; e.cnt = m_cnt; e.lockup = m_lockup;
      exp_q.push_back(e);
      n_tx++;
      $display("tx %0d: rst_n=%0b en=%0b code=%0d clr=%0b -> exp code=%0d locked=%0d wrap=%0d err=%0d cnt=%0d lockup=%0d",
               n_tx, rst_n, en, c, clr, e.code, e.locked, e.wrap, e.err, e.cnt, e.lockup);
   endtask

   task automatic drive(input bit en, input int c, input bit clr);
      logic [2:0] cv;
      cv = 3'(c);
      bus.i_en      = en;
      bus.i_q_a     = cv[2];
      bus.i_q_b     = cv[1];
      bus.i_q_c     = cv[0];
      bus.i_clr_err = clr;
   endtask

   // One transaction: inputs applied at the falling edge, sampled at the next rising edge
   task automatic step(input bit en, input int c, input bit clr);
      @(negedge clk);
      if (release_now) begin rst_n = 1'b1; release_now = 0; end
      drive(en, c, clr);
      if (!rst_n)  model_reset();
      else if (en) model_sample(c, clr);
      else         m_wrap = 0;
      push_exp(en, c, clr);
      mon_en = 1;
   endtask

   task automatic sample_out();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_code"},   int'(bus.o_code),    0);
      chk({tag, "_locked"}, int'(bus.o_locked),  0);
      chk({tag, "_wrap"},   int'(bus.o_wrap),    0);
      chk({tag, "_err"},    int'(bus.o_err),     0);
      chk({tag, "_errcnt"}, int'(bus.o_err_cnt), 0);
      chk({tag, "_lockup"}, int'(bus.o_lockup),  0);
   endtask

   task automatic reset_mid(input int c);
      @(negedge clk);
      chk("037_pre_code", int'(bus.o_code), 6);
      drive(1'b1, c, 1'b0);
      model_reset();
      push_exp(1'b1, c, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("037_async");
   endtask

   // Scoreboard monitor: one expected entry per rising edge once stimulus has started
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL mon_underflow: got no expected entry, expected one (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               chk("mon_code",   int'(bus.o_code),    e.code);
               chk("mon_locked", int'(bus.o_locked),  e.locked);
               chk("mon_wrap",   int'(bus.o_wrap),    e.wrap);
               chk("mon_err",    int'(bus.o_err),     e.err);
               chk("mon_errcnt", int'(bus.o_err_cnt), e.cnt);
               chk("mon_lockup", int'(bus.o_lockup),  e.lockup);
            end
         end
      end
   end

   initial begin
      int lastc, c;
      bit en, clr;
      rst_n = 1'b0;
      drive(1'b0, 0, 1'b0);
      model_reset();
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Acquisition on 0,3,6,2 then wrap on 2->3
      step(1, 0, 0);
      step(1, 3, 0);
      step(1, 6, 0); sample_out(); chk("033_not_locked", int'(bus.o_locked), 0);
      step(1, 2, 0); sample_out(); chk("033_locked", int'(bus.o_locked), 1);
                                   chk("033_no_wrap_62", int'(bus.o_wrap), 0);
      step(1, 3, 0); sample_out(); chk("033_wrap_23", int'(bus.o_wrap), 1);
      step(1, 6, 0); sample_out(); chk("033_wrap_one_cycle", int'(bus.o_wrap), 0);
      step(1, 2, 0);
      step(1, 3, 0);

      // Illegal 6->3 while locked, then recovery and relock
      step(1, 6, 0);
      step(1, 3, 0); sample_out(); chk("034_err", int'(bus.o_err), 1);
                                   chk("034_errcnt", int'(bus.o_err_cnt), 1);
                                   chk("034_unlocked", int'(bus.o_locked), 0);
      step(1, 6, 0);
      step(1, 2, 0);
      step(1, 3, 0);
      step(1, 6, 0); sample_out(); chk("034_relocked", int'(bus.o_locked), 1);
      step(1, 2, 0);
      step(1, 3, 0);

      // Lock-up codes: clear first so the count starts at zero
      step(1, 6, 1); sample_out(); chk("035_cleared", int'(bus.o_err_cnt), 0);
      step(1, 7, 0); sample_out(); chk("035_fault_on_7", int'(bus.o_err_cnt), 1);
      step(1, 5, 0); sample_out(); chk("035_no_lockup_75", int'(bus.o_lockup), 0);
      step(1, 1, 0); sample_out(); chk("035_lockup_51", int'(bus.o_lockup), 1);
      step(1, 5, 0); sample_out(); chk("035_lockup_15", int'(bus.o_lockup), 1);
      step(1, 3, 0); sample_out(); chk("035_lockup_clear", int'(bus.o_lockup), 0);
                                   chk("035_not_locked", int'(bus.o_locked), 0);
      step(1, 6, 0);
      step(1, 2, 0);
      step(1, 3, 0); sample_out(); chk("035_relocked", int'(bus.o_locked), 1);

      // Enable held low: outputs frozen whatever the inputs do
      for (int i = 0; i < 5; i++) begin
         step(0, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
         sample_out();
         chk("038_hold_locked", int'(bus.o_locked), 1);
         chk("038_hold_code", int'(bus.o_code), 3);
         chk("038_hold_wrap", int'(bus.o_wrap), 0);
      end
      step(1, 6, 0); sample_out(); chk("038_resume_locked", int'(bus.o_locked), 1);
      step(1, 2, 0);
      step(1, 3, 0);

      // 300 faults: counter must saturate
      for (int i = 0; i < 300; i++) begin
         step(1, 1, 0);
         step(1, 3, 0);
         step(1, 6, 0);
         step(1, 2, 0);
         step(1, 3, 0);
      end
      sample_out();
      chk("036_saturated", int'(bus.o_err_cnt), ERR_MAX);
      chk("036_err", int'(bus.o_err), 1);
      step(1, 7, 1); sample_out(); chk("036_clr_vs_fault_cnt", int'(bus.o_err_cnt), 1);
                                   chk("036_clr_vs_fault_err", int'(bus.o_err), 1);
      step(1, 3, 0);
      step(1, 6, 1); sample_out(); chk("036_plain_clr_cnt", int'(bus.o_err_cnt), 0);
                                   chk("036_plain_clr_err", int'(bus.o_err), 0);
      step(1, 2, 0);
      step(1, 3, 0);
      step(1, 6, 0);

      // Asynchronous reset mid-loop, then relock after three transitions
      reset_mid(2);
      step(1, 2, 0);
      step(1, 3, 0);
      release_now = 1;
      step(1, 3, 0);
      step(1, 6, 0);
      step(1, 2, 0); sample_out(); chk("037_not_yet", int'(bus.o_locked), 0);
      step(1, 3, 0); sample_out(); chk("037_relocked", int'(bus.o_locked), 1);
                                   chk("037_no_wrap_on_lock", int'(bus.o_wrap), 0);

      // Random traffic biased towards legal successors
      lastc = 3;
      for (int i = 0; i < 800; i++) begin
         en  = ($urandom_range(0, 9) != 0);
         clr = ($urandom_range(0, 39) == 0);
         c   = ($urandom_range(0, 9) < 8) ? succ_tbl[lastc] : int'($urandom_range(0, 7));
         step(en, c, clr);
         if (en) lastc = c;
      end

      sample_out();
      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_monitor.md
SEQ_MONITOR -- requirements
Module: seq_monitor

Interface
REQ-001 Parameter LOCK_N, default 3: consecutive legal in-loop transitions required to declare lock.
REQ-002 Parameter ERR_W, default 8: width of the error counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  sample enable; when low, all state holds and no pulses are produced.
REQ-006 Q_A, Q_B, Q_C  input  1 each  counter state from the upstream 3-bit T-flip-flop counter; the code is {Q_A,Q_B,Q_C}, with Q_A as MSB.
REQ-007 clr_err  input  1  synchronous clear of err and err_cnt.
REQ-008 code  output  3  registered copy of the last sampled code.
REQ-009 locked  output  1  high while the FSM is in LOCKED.
REQ-010 wrap  output  1  one-cycle pulse on each completed loop, i.e. a 2->3 transition while LOCKED.
REQ-011 err  output  1  sticky fault flag.
REQ-012 err_cnt  output  ERR_W  saturating count of fault entries.
REQ-013 lockup  output  1  high while the sampled code alternates between 1 and 5.

Function
REQ-014 Successor table: 0->3, 3->6, 6->2, 2->3, 4->6, 1->5, 5->1, 7->5.
REQ-015 The operating loop is {3,6,2}; 0 and 4 are entry codes; 1, 5 and 7 are lock-up codes.
REQ-016 Legal transition: prev is not in {1,5,7}, and cur equals succ(prev); prev and cur are consecutive enabled samples.
REQ-017 FSM states are IDLE, HUNT, LOCKED and FAULT.
REQ-018 IDLE: on the first enabled cycle, capture the code into prev and go to HUNT with run=0.
REQ-019 HUNT: on a legal transition with cur in the loop, run increments; otherwise run=0.
REQ-020 HUNT: when run reaches LOCK_N, go to LOCKED; locked rises in the same edge.
REQ-021 LOCKED: a legal transition stays in LOCKED; a 2->3 transition asserts wrap for exactly one cycle.
REQ-022 LOCKED: an illegal transition, or cur in {1,5,7}, goes to FAULT in one edge; err is set and err_cnt is incremented.
REQ-023 FAULT: when cur is in the loop, go to HUNT with run=0; otherwise stay in FAULT.
REQ-024 HUNT: an illegal transition does not raise err and does not increment err_cnt (acquisition only).
REQ-025 lockup is set when two consecutive samples are {1,5} or {5,1}; it is cleared on the first sample outside {1,5}.
REQ-026 err_cnt saturates at 2^ERR_W-1 and never wraps.
REQ-027 clr_err together with a new fault in the same cycle gives err_cnt=1 and err=1; the fault wins over the clear.
REQ-028 Latency: every output reflects the sample taken at edge N immediately after edge N; there are no combinational paths from inputs to outputs.

Reset
REQ-029 Asserting rst (low) at any time, including mid-loop, forces: FSM=IDLE, prev=0, run=0, code=0, locked=0, wrap=0, err=0, err_cnt=0, lockup=0.
REQ-030 After rst deasserts, the first enabled edge behaves as the IDLE capture in REQ-018; no wrap and no fault can occur on that edge.

Structure
REQ-031 Package seq_monitor_pkg SHALL hold: the FSM state encoding, the successor table as 8 constants, the loop-membership set, and the lock-up-code set.
REQ-032 Sub-module sat_counter (parameterised width, inc and clr inputs, increment dominates clear) SHALL implement err_cnt; all other logic is in seq_monitor.

Verification
REQ-033 Reset, then en=1 with codes 0,3,6,2,3 -> locked=1 after the 3rd legal transition (0->3->6->2); no wrap on 6->2; wrap=1 for one cycle on 2->3.
REQ-034 LOCKED, then code 6 followed by 3 (illegal) -> FAULT, err=1, err_cnt=1, locked=0; a subsequent 6,2,3 returns to HUNT and then relocks.
REQ-035 LOCKED, then codes 7,5,1,5 -> fault on 7, err_cnt=1; lockup=1 from the 5,1 pair onward; the next sample 3 clears lockup and the FSM returns to HUNT.
REQ-036 Force 300 faults with ERR_W=8 -> err_cnt holds at 255; clr_err coinciding with a fault -> err_cnt=1, err=1.
REQ-037 Assert rst low mid-loop with code=6 -> all outputs 0 immediately (asynchronous); after release, the sequence 3,6,2,3 relocks in 3 transitions.
REQ-038 Hold en=0 for 5 cycles while the inputs change arbitrarily -> no output change and no wrap; resuming with a legal successor of the last enabled sample keeps LOCKED.
